// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - parametrised UART transmitter with one-entry holding register
//
// Serialises producer bytes onto the TX pin as start, DATA_BITS data bits
// (LSB first), optional parity and STOP_BITS stop bits. A holding register
// accepts the next byte while a frame is on the line so frames can follow
// each other without an idle gap.
//
// Ports:
//   i_clk          sole clock
//   i_rst          asynchronous active-high reset
//   i_tx_byte_rdy  producer valid; accepted when high together with o_tx_ready
//   i_tx_byte      byte to send, sampled on acceptance
//   o_tx_ready     holding register empty
//   o_tx_busy      frame on the line or byte pending
//   o_tx           serial line, idle high, registered
//   o_tx_done      one-cycle pulse in the first cycle after each frame
module uart_tx_cfg #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_tx_byte_rdy,
  input  logic [DATA_BITS-1:0] i_tx_byte,
  output logic                 o_tx_ready,
  output logic                 o_tx_busy,
  output logic                 o_tx,
  output logic                 o_tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = (STOP_BITS == 2);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_tx_cfg: CLKS_PER_BIT must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_cfg: DATA_BITS must be in 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 stop_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] hold_q;
  logic                 hold_full_q;
  logic                 tx_q;
  logic                 done_q;

  logic                 accept;
  logic                 bit_end;
  logic [IDX_W-1:0]     idx_next;
  logic                 parity_bit;

  assign accept   = i_tx_byte_rdy & ~hold_full_q;
  assign bit_end  = (cnt_q == CNT_LAST);
  assign idx_next = idx_q + 1'b1;
  // The data register is indexed rather than shifted so the captured byte
  // stays intact for the parity bit: even = XOR of data, odd = its inverse.
  assign parity_bit = (PARITY == 1) ? ~^shift_q : ^shift_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      stop_q      <= 1'b0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // Outside IDLE an accepted byte waits in the holding register; in IDLE
      // it goes straight into the data register below.
      if (accept && state_q != S_IDLE) begin
        hold_q      <= i_tx_byte;
        hold_full_q <= 1'b1;
      end

      if (state_q != S_IDLE) begin
        cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          tx_q   <= 1'b1;
          cnt_q  <= '0;
          idx_q  <= '0;
          stop_q <= 1'b0;
          if (hold_full_q) begin
            shift_q     <= hold_q;
            hold_full_q <= 1'b0;
            state_q     <= S_START;
            tx_q        <= 1'b0;
          end else if (accept) begin
            shift_q <= i_tx_byte;
            state_q <= S_START;
            tx_q    <= 1'b0;
          end
        end

        S_START: begin
          if (bit_end) begin
            state_q <= S_DATA;
            idx_q   <= '0;
            tx_q    <= shift_q[0];
          end
        end

        S_DATA: begin
          if (bit_end) begin
            if (idx_q == IDX_LAST) begin
              if (PARITY != 0) begin
                state_q <= S_PARITY;
                tx_q    <= parity_bit;
              end else begin
                state_q <= S_STOP;
                stop_q  <= 1'b0;
                tx_q    <= 1'b1;
              end
            end else begin
              idx_q <= idx_next;
              tx_q  <= shift_q[idx_next];
            end
          end
        end

        S_PARITY: begin
          if (bit_end) begin
            state_q <= S_STOP;
            stop_q  <= 1'b0;
            tx_q    <= 1'b1;
          end
        end

        S_STOP: begin
          if (bit_end) begin
            if (stop_q == STOP_LAST) begin
              done_q <= 1'b1;
              // A pending byte starts immediately, leaving no idle cycle.
              if (hold_full_q) begin
                shift_q     <= hold_q;
                hold_full_q <= 1'b0;
                state_q     <= S_START;
                tx_q        <= 1'b0;
              end else begin
                state_q <= S_IDLE;
                tx_q    <= 1'b1;
              end
            end else begin
              stop_q <= 1'b1;
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign o_tx       = tx_q;
  assign o_tx_done  = done_q;
  assign o_tx_ready = ~hold_full_q;
  assign o_tx_busy  = (state_q != S_IDLE) | hold_full_q;

endmodule
